sprite_ram_arbiter: RTL
=======================

// Module: sprite_ram_arbiter
// PURPOSE
//  Shares the single read port of one sprite/background frame RAM (1-cycle registered read) among
//  N_REQ pixel-fetch requesters (background, ducks, dog, crosshair) using round-robin arbitration.
//  Supports locked bursts and returns read data to the winning requester with a one-hot valid.
//  Sits between the per-layer sprite fetch units and the frame RAM instance, ahead of the colour mapper.
// PARAMETERS
//  N_REQ      4   number of read requesters (2..8)
//  ADDR_W     19  RAM address width
//  DATA_W     5   RAM data width (palette index)
//  BURST_MAX  8   max consecutive beats granted under lock before forced rotation (1..255)
// PORTS
//  Clk               in   1               system clock, all logic on posedge
//  Reset_n           in   1               asynchronous active-low reset
//  req               in   N_REQ           read request, held until granted
//  req_lock          in   N_REQ           request burst lock, sampled with req
//  req_addr          in   N_REQ*ADDR_W    read address per requester, slice i = requester i
//  gnt               out  N_REQ           one-hot grant; transfer when req[i]&gnt[i]
//  rd_valid          out  N_REQ           one-hot pulse: rd_data belongs to requester i
//  rd_data           out  DATA_W          read data, valid only when |rd_valid
//  ram_read_address  out  ADDR_W          to RAM read_address
//  ram_we            out  1               to RAM we
//  ram_write_address out  ADDR_W          to RAM write_address
//  ram_data_In       out  DATA_W          to RAM data_In
//  ram_data_Out      in   DATA_W          from RAM data_Out
//  wr_req/wr_addr/wr_data in 1/ADDR_W/DATA_W, wr_gnt out 1   -- only with SPRITE_ARB_WRITE_EN
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, tag pipe cleared;
//    gnt=0, rd_valid=0, rd_data=0, ram_we=0, ram_read_address=0. In-flight reads dropped, never returned.
//  - Arbitration is combinational in cycle t: gnt, ram_read_address = req_addr[winner].
//    RAM samples at t edge; rd_valid[winner]=1, rd_data=ram_data_Out in cycle t+1 (latency 1, full throughput).
//  - IDLE: winner = first i with req[i], scanning rr_ptr, rr_ptr+1 .. wrapping mod N_REQ.
//    On grant: rr_ptr <= winner+1 (wrap N_REQ-1 -> 0). If req_lock[winner]: owner<=winner,
//    beat_cnt<=1, -> BURST. No req: gnt=0, ram_read_address holds last value, no rd_valid next cycle.
//  - BURST: gnt[owner]=1 iff req[owner]; beat_cnt++ per transfer. Exit to IDLE (re-arbitrate same cycle)
//    when req[owner]=0, req_lock[owner]=0 on a transfer (that beat is last), or beat_cnt==BURST_MAX
//    (owner's req is ignored that cycle; others get priority from rr_ptr=owner+1).
//  - Never more than one gnt bit; rd_valid one-hot or zero; rd_data=0 when rd_valid==0.
//  - req_addr of a non-granted requester is don't-care; a dropped req without gnt is legal.
// CONFIGURATION
//  SPRITE_ARB_WRITE_EN defined: adds wr_req/wr_addr/wr_data/wr_gnt. wr_req has absolute priority:
//    wr_gnt=wr_req combinationally, all gnt=0 that cycle, ram_we=1, ram_write_address=wr_addr,
//    ram_data_In=wr_data; BURST beat_cnt and rr_ptr frozen (write does not count as a beat).
//  Not defined: write ports absent; ram_we=0, ram_write_address=0, ram_data_In=0 constants.
// STRUCTURE
//  Package sprite_arb_pkg: arb_state_e {IDLE, BURST}; MAX_REQ=8; tag type logic [MAX_REQ-1:0].
//  Sub-module rr_pick: rotating priority encoder (req, rr_ptr -> one-hot winner, found flag).
//  Top holds FSM, beat counter, tag/valid pipeline register, RAM port muxing.
// TESTING (bench models RAM as 1-cycle registered array, preloaded mem[a]=a[4:0])
//  1 Reset: Reset_n=0 mid-stream with req=4'b1111 -> gnt=0, rd_valid=0 asynchronously; next rd_valid after release only for new grants.
//  2 RR fairness: req=4'b1111 held, no lock, addr_i=i*16 -> gnt 0,1,2,3,0..; rd_valid lags gnt by 1, rd_data=addr&5'h1F.
//  3 Wrap: rr_ptr=3, req=4'b1001 -> gnt[3] then gnt[0], rr_ptr wraps to 0 then 1.
//  4 Burst cap: req[1]&lock[1] held, req[2]=1, BURST_MAX=8 -> 8 consecutive gnt[1], then gnt[2] immediately.
//  5 Lock release: lock[0] deasserts on beat 3 -> beats 1-3 to req 0, cycle 4 re-arbitrated from rr_ptr=1.
//  6 (SPRITE_ARB_WRITE_EN) wr_req during burst beat 2, wr_addr=5, wr_data=7 -> ram_we=1, gnt=0 that cycle;
//    burst resumes with beat_cnt unchanged; later read of addr 5 returns 7.

Source files
------------

// File: rtl/sprite_ram_arbiter_pkg.sv
// Shared types for the sprite frame-RAM read arbiter: FSM state, return-tag type
// and the round-robin pointer increment helper.
package sprite_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  // One-hot tag of the requester whose read is in flight in the RAM
  typedef logic [MAX_REQ-1:0] tag_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sprite_ram_arbiter_if.sv
// Requester/RAM bus of the sprite RAM arbiter. The write port only exists when
// SPRITE_ARB_WRITE_EN is defined.
interface sprite_ram_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 5
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic [ADDR_W-1:0]       ram_read_address;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_write_address;
  logic [DATA_W-1:0]       ram_data_In;
  logic [DATA_W-1:0]       ram_data_Out;

`ifdef SPRITE_ARB_WRITE_EN
  logic                    wr_req;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_gnt;

  modport master (
    output req, req_lock, req_addr, ram_data_Out, wr_req, wr_addr, wr_data,
    input  gnt, rd_valid, rd_data, ram_read_address, ram_we, ram_write_address,
           ram_data_In, wr_gnt
  );

  modport slave (
    input  req, req_lock, req_addr, ram_data_Out, wr_req, wr_addr, wr_data,
    output gnt, rd_valid, rd_data, ram_read_address, ram_we, ram_write_address,
           ram_data_In, wr_gnt
  );
`else
  modport master (
    output req, req_lock, req_addr, ram_data_Out,
    input  gnt, rd_valid, rd_data, ram_read_address, ram_we, ram_write_address,
           ram_data_In
  );

  modport slave (
    input  req, req_lock, req_addr, ram_data_Out,
    output gnt, rd_valid, rd_data, ram_read_address, ram_we, ram_write_address,
           ram_data_In
  );
`endif

endinterface

// File: rtl/sprite_ram_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after i_ptr, wrapping
// modulo N_REQ, returned both one-hot and as an index.
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    logic [IDX_W-1:0] w_pos;
    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves one unassigned and no latch is inferred.
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = IDX_W'((int'(i_ptr) + k) % N_REQ);
      if (!o_found && i_req[w_pos]) begin
        o_found        = 1'b1;
        o_idx          = w_pos;
        o_grant[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Round-robin arbiter sharing one registered-read frame RAM among N_REQ pixel
// fetchers, with capped locked bursts. Optional write port: SPRITE_ARB_WRITE_EN.
module sprite_ram_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 5,
  parameter int BURST_MAX = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  sprite_ram_arbiter_if.slave  bus
);

  localparam int               IDX_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

  arb_state_e        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_owner;
  logic [7:0]        r_beat_cnt;
  tag_t              r_tag;
  logic [ADDR_W-1:0] r_last_addr;

  logic              w_wr_active;
  logic              w_arb_en;
  logic              w_cap;
  logic              w_hold;
  logic              w_found;
  logic              w_xfer;
  logic [N_REQ-1:0]  w_owner_oh;
  logic [N_REQ-1:0]  w_pick_req;
  logic [N_REQ-1:0]  w_pick_oh;
  logic [N_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [ADDR_W-1:0] w_sel_addr;

`ifdef SPRITE_ARB_WRITE_EN
  assign w_wr_active           = bus.wr_req & Reset_n;
  assign bus.wr_gnt            = w_wr_active;
  assign bus.ram_we            = w_wr_active;
  assign bus.ram_write_address = w_wr_active ? bus.wr_addr : '0;
  assign bus.ram_data_In       = w_wr_active ? bus.wr_data : '0;
`else
  assign w_wr_active           = 1'b0;
  assign bus.ram_we            = 1'b0;
  assign bus.ram_write_address = '0;
  assign bus.ram_data_In       = '0;
`endif

  // A write or an asserted reset blocks every read grant in the current cycle
  assign w_arb_en   = Reset_n & ~w_wr_active;
  assign w_owner_oh = ONE << r_owner;
  assign w_cap      = (r_state == BURST) && (r_beat_cnt == 8'(BURST_MAX));
  assign w_hold     = (r_state == BURST) && !w_cap && bus.req[r_owner];

  // At the burst cap the owner sits out one arbitration round
  assign w_pick_req = bus.req & ~(w_cap ? w_owner_oh : '0);

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (w_pick_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  assign w_xfer     = w_arb_en & (w_hold | w_found);
  assign w_sel_idx  = w_hold ? r_owner : w_pick_idx;
  assign w_sel_addr = bus.req_addr[w_sel_idx*ADDR_W +: ADDR_W];
  assign w_gnt      = !w_arb_en ? '0 : (w_hold ? w_owner_oh : w_pick_oh);

  assign bus.gnt              = w_gnt;
  assign bus.ram_read_address = w_xfer ? w_sel_addr : r_last_addr;
  assign bus.rd_valid         = r_tag[N_REQ-1:0];
  assign bus.rd_data          = (|r_tag) ? bus.ram_data_Out : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_beat_cnt  <= '0;
      r_tag       <= '0;
      r_last_addr <= '0;
    end else if (w_wr_active) begin
      // Write cycle: no read issued, burst progress and pointer frozen
      r_tag <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every decision below uses the
      // pre-edge register values regardless of statement order.
      r_tag <= tag_t'(w_gnt);
      if (w_xfer) r_last_addr <= w_sel_addr;
      if (w_hold) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        if (!bus.req_lock[r_owner]) r_state <= IDLE;
      end else if (w_found) begin
        r_rr_ptr <= IDX_W'(wrap_inc(int'(w_pick_idx), N_REQ));
        if (bus.req_lock[w_pick_idx]) begin
          r_state    <= BURST;
          r_owner    <= w_pick_idx;
          r_beat_cnt <= 8'd1;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end

endmodule
